// File: rtl/mips_bus_arbiter_pkg.sv
// Shared types for the MIPS bus arbiter.
//   arb_port_t : identifies a requester (fetch port I or load/store port D)
//   BE_ALL     : byte lanes driven for instruction fetches (always full word)
package mips_bus_arbiter_pkg;

   typedef enum logic {ARB_PORT_I = 1'b0, ARB_PORT_D = 1'b1} arb_port_t;

   localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/mips_bus_arbiter_arb_rr2.sv
// Two-way combinational arbiter for the MIPS bus arbiter.
// Ports:
//   req_i, req_d      : in  requests from fetch and load/store ports
//   last              : in  port that completed the most recent transfer
//   fixed             : in  1 = D always wins a tie, 0 = alternate on ties
//   grant_i, grant_d  : out one-hot (or zero) grant
module arb_rr2
   import mips_bus_arbiter_pkg::*;
(
   input  logic      req_i,
   input  logic      req_d,
   input  arb_port_t last,
   input  logic      fixed,
   output logic      grant_i,
   output logic      grant_d
);

   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (req_i && req_d) begin
         // On a tie the port that did not go last wins, unless D is pinned.
         if (fixed || (last == ARB_PORT_I)) grant_d = 1'b1;
         else                               grant_i = 1'b1;
      end else if (req_i) begin
         grant_i = 1'b1;
      end else if (req_d) begin
         grant_d = 1'b1;
      end
   end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Shares one Avalon-MM master bus between the MIPS fetch port (I) and the
// load/store port (D). Grant is combinational (zero cycle); once a granted
// transfer stalls, the bus is locked to that port until it completes.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   i_address/i_read               : fetch request (read only)
//   i_waitreq/i_readdata           : fetch stall / read data
//   d_address/d_read/d_write/
//   d_byteenable/d_writedata       : load/store request
//   d_waitreq/d_readdata           : load/store stall / read data
//   address/read/write/byteenable/
//   writedata/waitrequest/readdata : Avalon-MM master bus
//   i_xfers, d_xfers               : saturating completed-transfer counters
module mips_bus_arbiter
   import mips_bus_arbiter_pkg::*;
#(
   parameter int FIXED_PRIO = 0,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      i_address,
   input  logic             i_read,
   output logic             i_waitreq,
   output logic [31:0]      i_readdata,
   input  logic [31:0]      d_address,
   input  logic             d_read,
   input  logic             d_write,
   input  logic [3:0]       d_byteenable,
   input  logic [31:0]      d_writedata,
   output logic             d_waitreq,
   output logic [31:0]      d_readdata,
   output logic [31:0]      address,
   output logic             read,
   output logic             write,
   output logic [3:0]       byteenable,
   output logic [31:0]      writedata,
   input  logic             waitrequest,
   input  logic [31:0]      readdata,
   output logic [CNT_W-1:0] i_xfers,
   output logic [CNT_W-1:0] d_xfers
);

   logic      req_i;
   logic      req_d;
   logic      lock;
   arb_port_t owner;
   arb_port_t last;
   logic      rr_grant_i;
   logic      rr_grant_d;
   logic      grant_i;
   logic      grant_d;
   logic      active_i;
   logic      active_d;
   logic      bus_active;

   assign req_i = i_read;
   assign req_d = d_read | d_write;

   arb_rr2 u_arb (
      .req_i   (req_i),
      .req_d   (req_d),
      .last    (last),
      .fixed   (FIXED_PRIO != 0),
      .grant_i (rr_grant_i),
      .grant_d (rr_grant_d)
   );

   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (lock) begin
         grant_i = (owner == ARB_PORT_I);
         grant_d = (owner == ARB_PORT_D);
      end else begin
         grant_i = rr_grant_i;
         grant_d = rr_grant_d;
      end
   end

   // A locked owner that drops its request leaves the bus idle for a cycle.
   assign active_i   = grant_i & req_i;
   assign active_d   = grant_d & req_d;
   assign bus_active = active_i | active_d;

   always_comb begin
      address    = 32'h0;
      read       = 1'b0;
      write      = 1'b0;
      byteenable = 4'h0;
      writedata  = 32'h0;
      if (active_i) begin
         address    = i_address;
         read       = 1'b1;
         byteenable = BE_ALL;
      end else if (active_d) begin
         address    = d_address;
         read       = d_read;
         write      = d_write;
         byteenable = d_byteenable;
         writedata  = d_writedata;
      end
   end

   // A requesting port that is not on the bus is always stalled.
   assign i_waitreq  = active_i ? waitrequest : req_i;
   assign d_waitreq  = active_d ? waitrequest : req_d;
   assign i_readdata = readdata;
   assign d_readdata = readdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         lock    <= 1'b0;
         owner   <= ARB_PORT_I;
         last    <= ARB_PORT_D;
         i_xfers <= '0;
         d_xfers <= '0;
      end else if (bus_active) begin
         if (waitrequest) begin
            lock  <= 1'b1;
            owner <= active_d ? ARB_PORT_D : ARB_PORT_I;
         end else begin
            lock <= 1'b0;
            last <= active_d ? ARB_PORT_D : ARB_PORT_I;
            if (active_i && (i_xfers != '1)) i_xfers <= i_xfers + CNT_W'(1);
            if (active_d && (d_xfers != '1)) d_xfers <= d_xfers + CNT_W'(1);
         end
      end else begin
         lock <= 1'b0;
      end
   end

endmodule
